// File: rtl/uart_msg_pkg.sv
// Shared constants and FSM state encoding for the UART message transmitter.
// Frame layout: SOF, LEN (= CMD + payload count), CMD, payload, optional checksum.
package uart_msg_pkg;

  localparam logic [7:0] SOF_BYTE      = 8'h7E;
  localparam logic [7:0] CMD_DM_ENABLE = 8'hA8;
  localparam logic [7:0] CMD_DM_SET    = 8'hAC;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SOF     = 3'd1;
  localparam state_t ST_LEN     = 3'd2;
  localparam state_t ST_CMD     = 3'd3;
  localparam state_t ST_PAYLOAD = 3'd4;
  localparam state_t ST_CSUM    = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  function automatic logic [7:0] len_byte(input logic [3:0] payloadLen);
    return {4'd0, payloadLen} + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// o_ready also rises in the last stop-bit cycle so a new byte can follow with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1736
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_inStop,
  output logic       o_done,
  output logic       o_tx
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      STOP_IDX = 4'd9;

  logic             r_active;
  logic [3:0]       r_bitIdx;
  logic [CNT_W-1:0] r_baudCnt;
  logic [7:0]       r_data;
  logic             r_tx;

  logic w_bitEnd;
  logic w_inStop;
  logic w_done;
  logic w_ready;
  logic w_start;

  assign w_bitEnd = (r_baudCnt == LAST_CNT);
  assign w_inStop = r_active && (r_bitIdx == STOP_IDX);
  assign w_done   = w_inStop && w_bitEnd;
  assign w_ready  = !r_active || w_done;
  assign w_start  = i_load && w_ready;

  assign o_ready  = w_ready;
  assign o_inStop = w_inStop;
  assign o_done   = w_done;
  assign o_tx     = r_tx;

  // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_bitIdx  <= 4'd0;
      r_baudCnt <= '0;
      r_data    <= 8'h00;
      r_tx      <= 1'b1;
    end else if (w_start) begin
      r_active  <= 1'b1;
      r_bitIdx  <= 4'd0;
      r_baudCnt <= '0;
      r_data    <= i_data;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_baudCnt <= '0;
        if (r_bitIdx == STOP_IDX) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bitIdx <= r_bitIdx + 4'd1;
          r_tx     <= (r_bitIdx == 4'd8) ? 1'b1 : r_data[r_bitIdx[2:0]];
        end
      end else begin
        r_baudCnt <= r_baudCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Framed UART message transmitter: SOF, LEN, CMD, payload over one 8N1 serializer.
// Define UART_MSG_TX_CHECKSUM_EN to append an XOR checksum of LEN, CMD and payload.
module uart_msg_tx
  import uart_msg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 57600,
  parameter int MAX_PAYLOAD = 15
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [3:0] req_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       ct_UartTx,
  output logic       busy
);

  localparam int         CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam logic [3:0] MAX_LEN      = 4'(MAX_PAYLOAD);

  state_t     r_state;
  logic [7:0] r_cmd;
  logic [3:0] r_len;
  logic [3:0] r_plCnt;
`ifdef UART_MSG_TX_CHECKSUM_EN
  logic [7:0] r_csum;
`endif

  logic       w_txReady;
  logic       w_txInStop;
  logic       w_txDone;
  logic       w_load;
  logic [7:0] w_txData;
  logic       w_accept;
  logic       w_plTake;
  logic [3:0] w_lenClamped;

  assign w_lenClamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign pl_ready     = (r_state == ST_PAYLOAD) && w_txReady && (r_plCnt != r_len);
  assign w_plTake     = pl_ready && pl_valid;

  // Selects which byte, if any, enters the serializer this cycle.
  always_comb begin
    w_load   = 1'b0;
    w_txData = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load   = 1'b1;
          w_txData = SOF_BYTE;
        end
      end
      ST_SOF: begin
        if (w_txDone) begin
          w_load   = 1'b1;
          w_txData = len_byte(r_len);
        end
      end
      ST_LEN: begin
        if (w_txDone) begin
          w_load   = 1'b1;
          w_txData = r_cmd;
        end
      end
`ifdef UART_MSG_TX_CHECKSUM_EN
      ST_CMD: begin
        if (w_txDone && (r_len == 4'd0)) begin
          w_load   = 1'b1;
          w_txData = r_csum;
        end
      end
`endif
      ST_PAYLOAD: begin
        if (w_plTake) begin
          w_load   = 1'b1;
          w_txData = pl_data;
        end
`ifdef UART_MSG_TX_CHECKSUM_EN
        else if (w_txDone && (r_plCnt == r_len)) begin
          w_load   = 1'b1;
          w_txData = r_csum;
        end
`endif
      end
      default: ;
    endcase
  end

  // CMD hands over to PAYLOAD at the start of its stop bit so that pl_ready
  // can rise in the final stop cycle and the first payload byte follows with no gap.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= 8'h00;
      r_len   <= 4'd0;
      r_plCnt <= 4'd0;
`ifdef UART_MSG_TX_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SOF;
            r_cmd   <= req_cmd;
            r_len   <= w_lenClamped;
            r_plCnt <= 4'd0;
`ifdef UART_MSG_TX_CHECKSUM_EN
            r_csum  <= len_byte(w_lenClamped) ^ req_cmd;
`endif
          end
        end
        ST_SOF: if (w_txDone) r_state <= ST_LEN;
        ST_LEN: if (w_txDone) r_state <= ST_CMD;
        ST_CMD: begin
          if (r_len != 4'd0) begin
            if (w_txInStop) r_state <= ST_PAYLOAD;
          end else if (w_txDone) begin
`ifdef UART_MSG_TX_CHECKSUM_EN
            r_state <= ST_CSUM;
`else
            r_state <= ST_DONE;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (w_plTake) begin
            r_plCnt <= r_plCnt + 4'd1;
`ifdef UART_MSG_TX_CHECKSUM_EN
            r_csum  <= r_csum ^ pl_data;
`endif
          end else if (w_txDone && (r_plCnt == r_len)) begin
`ifdef UART_MSG_TX_CHECKSUM_EN
            r_state <= ST_CSUM;
`else
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef UART_MSG_TX_CHECKSUM_EN
        ST_CSUM: if (w_txDone) r_state <= ST_DONE;
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_txByte (
    .CLK     (CLK),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_txData),
    .o_ready (w_txReady),
    .o_inStop(w_txInStop),
    .o_done  (w_txDone),
    .o_tx    (ct_UartTx)
  );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: a line decoder pops expected bytes from a scoreboard queue.
// Runs at 16 clocks per bit so the longest frames stay short.
module tb_uart_msg_tx;

  localparam int CLK_FREQ_HZ = 1_600_000;
  localparam int BAUD        = 100_000;
  localparam int CPB         = 16;
  localparam int CLK_NS      = 10;
  localparam int BYTE_NS     = 10 * CPB * CLK_NS;
  localparam int MAXP        = 15;
  localparam int STALL_CYC   = 5000;

  logic       CLK = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic [3:0] req_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       ct_UartTx;
  logic       busy;

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         rstEpoch    = 0;
  logic [7:0] expQ[$];
  time        startTimes[$];
  logic [7:0] plBytes[16];

  uart_msg_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .MAX_PAYLOAD(MAXP)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd  (req_cmd),
    .req_len  (req_len),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .ct_UartTx(ct_UartTx),
    .busy     (busy)
  );

  always #(CLK_NS / 2) CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples each bit mid-period and checks against the next expected byte.
  always begin : lineMonitor
    time        tStart;
    int         ep;
    logic [9:0] fr;
    logic [7:0] expB;
    @(negedge ct_UartTx);
    tStart = $time;
    ep     = rstEpoch;
    repeat (CPB / 2) @(posedge CLK);
    @(negedge CLK);
    fr[0] = ct_UartTx;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(negedge CLK);
      fr[i] = ct_UartTx;
    end
    if (ep == rstEpoch) begin
      expB = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
      startTimes.push_back(tStart);
      checkOutput("line_byte", {22'd0, fr}, {22'd0, 1'b1, expB, 1'b0});
    end
  end

  task automatic applyStimulus(input logic [7:0] cmd, input logic [3:0] len,
                               input int stallIdx, input bit pulseBusy, input bit checkGaps);
    int         n;
    int         nb;
    int         budget;
    int         lows;
    logic [7:0] csum;
    time        acceptT;
    time        fallT;
    n = (int'(len) > MAXP) ? MAXP : int'(len);
    startTimes.delete();
    expQ.push_back(8'h7E);
    expQ.push_back(8'(n + 1));
    expQ.push_back(cmd);
    csum = 8'(n + 1) ^ cmd;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(plBytes[i]);
      csum = csum ^ plBytes[i];
    end
    nb = n + 3;
`ifdef UART_MSG_TX_CHECKSUM_EN
    expQ.push_back(csum);
    nb = nb + 1;
`endif

    @(negedge CLK);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_len   = len;
    pl_data   = plBytes[0];
    pl_valid  = (n > 0);
    @(posedge CLK);
    acceptT = $time;
    @(negedge CLK);
    req_valid = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);

    if (pulseBusy) begin
      req_cmd   = 8'h99;
      req_len   = 4'd1;
      req_valid = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        checkOutput("req_ready_ignored", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
    end

    for (int i = 0; i < n; i++) begin
      if (i == stallIdx) begin
        pl_valid = 1'b0;
        lows     = 0;
        for (int c = 0; c < STALL_CYC; c++) begin
          @(negedge CLK);
          if (c >= 10 * CPB + 2 && ct_UartTx !== 1'b1) lows++;
        end
        checkOutput("underrun_line_high", 32'(lows), 32'd0);
      end
      pl_data  = plBytes[i];
      pl_valid = 1'b1;
      budget   = 0;
      while (!pl_ready && budget < 40 * CPB) begin
        @(negedge CLK);
        budget++;
      end
      checkOutput("pl_ready_wait", 32'(pl_ready), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      pl_valid = 1'b0;
    end

    budget = 0;
    do begin
      @(posedge CLK);
      #1;
      budget++;
    end while (busy && budget < 30 * 10 * CPB);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    fallT = $time - 1;

    checkOutput("byte_count", 32'(startTimes.size()), 32'(nb));
    if (startTimes.size() == nb) begin
      checkOutput("start_latency", 32'(startTimes[0]), 32'(acceptT));
      checkOutput("busy_fall_time", 32'(fallT),
                  32'(startTimes[nb-1] + (10 * CPB + 1) * CLK_NS));
      if (checkGaps) begin
        for (int i = 1; i < nb; i++)
          checkOutput("byte_gap", 32'(startTimes[i] - startTimes[i-1]), 32'(BYTE_NS));
      end
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_cmd   = 8'h00;
    req_len   = 4'd0;
    pl_data   = 8'h00;
    pl_valid  = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_tx", 32'(ct_UartTx), 32'd1);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_pl_ready", 32'(pl_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    plBytes[0] = 8'h00; plBytes[1] = 8'h00; plBytes[2] = 8'h00;
    applyStimulus(8'hA8, 4'd3, -1, 1'b0, 1'b1);

    plBytes[0] = 8'h03; plBytes[1] = 8'h60;
    applyStimulus(8'hAC, 4'd2, -1, 1'b0, 1'b1);

    applyStimulus(8'h55, 4'd0, -1, 1'b0, 1'b1);

    plBytes[0] = 8'h5A; plBytes[1] = 8'hC3;
    applyStimulus(8'h12, 4'd2, 1, 1'b0, 1'b0);

    // Abort a frame while CMD 0xF0 is driving a low data bit.
    expQ.push_back(8'h7E);
    expQ.push_back(8'h02);
    @(negedge CLK);
    req_valid = 1'b1;
    req_cmd   = 8'hF0;
    req_len   = 4'd1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (2 * 10 * CPB + 2 * CPB + CPB / 2 - 1) @(posedge CLK);
    #3;
    checkOutput("line_low_before_reset", 32'(ct_UartTx), 32'd0);
    rstEpoch++;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", 32'(ct_UartTx), 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("abort_prefix_drained", 32'(expQ.size()), 32'd0);
    repeat (12 * CPB) @(negedge CLK);
    checkOutput("post_reset_line_idle", 32'(ct_UartTx), 32'd1);
    expQ.delete();

    plBytes[0] = 8'h81;
    applyStimulus(8'hA8, 4'd1, -1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) plBytes[i] = 8'(i * 37 + 5);
    applyStimulus(8'hAC, 4'd15, -1, 1'b1, 1'b1);
    repeat (20) @(negedge CLK);
    checkOutput("busy_request_not_queued", 32'(busy), 32'd0);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
